// File: rtl/riscv_pkg.sv
// riscv_pkg: InstFormat codes, base opcodes and the opcode-to-format predecoder shared by fetch and ImmGen
package riscv_pkg;
  typedef enum logic [2:0] {
    InstFormat_R  = 3'd0,
    InstFormat_I  = 3'd1,
    InstFormat_S  = 3'd2,
    InstFormat_SB = 3'd3,
    InstFormat_U  = 3'd4,
    InstFormat_UJ = 3'd5
  } inst_format_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  function automatic inst_format_e predecode(input logic [6:0] opc);
    return (opc == OPC_OP_IMM || opc == OPC_LOAD || opc == OPC_JALR || opc == OPC_SYSTEM) ? InstFormat_I :
           (opc == OPC_STORE) ? InstFormat_S :
           (opc == OPC_BRANCH) ? InstFormat_SB :
           (opc == OPC_LUI || opc == OPC_AUIPC) ? InstFormat_U :
           (opc == OPC_JAL) ? InstFormat_UJ : InstFormat_R;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: power-of-two sync FIFO with flush; push while full is accepted only with a same-cycle pop
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop_ok, push_ok;
  always_comb begin
    pop_ok  = pop && cnt_q != '0;
    push_ok = push && !flush && (cnt_q != FULL || pop_ok);
    wr_d    = flush ? '0 : push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = flush ? '0 : pop_ok ? rd_q + AW'(1) : rd_q;
    cnt_d   = flush ? '0 :
              (push_ok && !pop_ok) ? cnt_q + ONE :
              (pop_ok && !push_ok) ? cnt_q - ONE : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_ok) mem_q[wr_q] <= din;
    end
  end
  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with redirect flush, stale-response dropping and a decode queue.
// Define FETCH_PREDECODE_EN to predecode and store the instruction format with each queue entry.
module fetch_unit import riscv_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [2:0]  if_format
);
  localparam int CW = $clog2(QDEPTH) + 1;
`ifdef FETCH_PREDECODE_EN
  localparam int W = 67;
`else
  localparam int W = 64;
`endif
  logic [31:0]   pc_q, pc_d, tag_q, tag_d, target;
  logic [CW-1:0] out_q, out_d, occ, count;
  logic [7:0]    drop_q, drop_d;
  logic          fire, rsp_hit, rsp_live, unused_ok;
  logic [W-1:0]  din, dout;
  assign target    = {redirect_pc[31:2], 2'b00};
  assign unused_ok = ^redirect_pc[1:0];
  // tag_q is the pc of the next live response: live responses return in order from the last redirect
  always_comb begin
    occ            = out_q + count;
    imem_req_valid = rst_n && !redirect_valid && occ < CW'(QDEPTH);
    fire           = imem_req_valid && imem_req_ready;
    rsp_hit        = imem_rsp_valid && (drop_q != '0 || out_q != '0);
    rsp_live       = imem_rsp_valid && drop_q == '0 && out_q != '0;
    pc_d           = redirect_valid ? target : fire ? pc_q + 32'd4 : pc_q;
    tag_d          = redirect_valid ? target : rsp_live ? tag_q + 32'd4 : tag_q;
    out_d          = redirect_valid ? '0 : out_q + CW'(fire) - CW'(rsp_live);
    drop_d         = redirect_valid ? drop_q + 8'(out_q) - 8'(rsp_hit) :
                     drop_q - 8'(imem_rsp_valid && drop_q != '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      tag_q  <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      tag_q  <= tag_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end
  fetch_queue #(.DEPTH(QDEPTH), .W(W)) u_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .push (rsp_live),
    .pop  (if_valid && if_ready),
    .din  (din),
    .dout (dout),
    .count(count)
  );
`ifdef FETCH_PREDECODE_EN
  assign din       = {tag_q, imem_rsp_data, predecode(imem_rsp_data[6:0])};
  assign if_format = dout[2:0];
  assign if_inst   = dout[34:3];
  assign if_pc     = dout[66:35];
`else
  assign din       = {tag_q, imem_rsp_data};
  assign if_format = InstFormat_R;
  assign if_inst   = dout[31:0];
  assign if_pc     = dout[63:32];
`endif
  assign imem_req_addr = pc_q;
  assign if_valid      = count != '0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; stimulus queues expected decode entries, a monitor checks each dequeue
module tb_fetch_unit;
  localparam int QD = 4;
  logic        clk = 0, rst_n = 0;
  logic        imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] imem_req_addr, imem_rsp_data = 0;
  logic        redirect_valid = 0, if_valid, if_ready = 0, rsp_en = 0;
  logic [31:0] redirect_pc = 0, if_inst, if_pc;
  logic [2:0]  if_format;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic [2:0] fmt;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] pend[$];
  int          n_chk = 0, n_fail = 0, ndeq = 0, nfire = 0;

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc), .if_format(if_format)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_inst(input logic [31:0] a);
    return a == 32'h300 ? 32'h00108093 : a == 32'h304 ? 32'h0010836F : {a[23:0], 8'h33};
  endfunction

  function automatic logic [2:0] exp_fmt(input logic [31:0] a);
`ifdef FETCH_PREDECODE_EN
    return a == 32'h300 ? 3'd1 : a == 32'h304 ? 3'd5 : 3'd0;
`else
    return (a == 32'h300) ? 3'd0 : 3'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = pc0 + 32'(4 * i);
      exp_q.push_back(exp_t'{pc: p, inst: mem_inst(p), fmt: exp_fmt(p)});
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_deq(input int n, input string name);
    int t, k;
    t = ndeq + n;
    k = 0;
    while (ndeq < t && k < 200) begin
      cyc(1);
      k++;
    end
    check(name, 32'(ndeq >= t), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] tgt, input int nexp);
    logic [31:0] al;
    al = {tgt[31:2], 2'b00};
    if_ready = 0;
    cyc(1);
    redirect_valid = 1;
    redirect_pc = tgt;
    exp_q.delete();
    cyc(1);
    redirect_valid = 0;
    push_exp(al, nexp);
    check("redir_addr", imem_req_addr, al);
    check("redir_if_valid_low", 32'(if_valid), 32'd0);
  endtask

  // instruction memory: in-order, one-cycle latency when rsp_en is set
  initial forever begin
    @(negedge clk);
    if (rsp_en && pend.size() > 0) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = mem_inst(pend.pop_front());
    end else begin
      imem_rsp_valid = 0;
    end
    if (imem_req_valid && imem_req_ready) begin
      pend.push_back(imem_req_addr);
      nfire++;
    end
  end

  // decode-side monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && if_valid && if_ready) begin
      ndeq++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_deq: got pc %h required no instruction", if_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_inst", if_inst, e.inst);
        check("if_format", {29'b0, if_format}, {29'b0, e.fmt});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int d0, f0;
    cyc(2);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_format", {29'b0, if_format}, 32'd0);
    check("rst_addr", imem_req_addr, 32'd0);
    // streaming from reset
    push_exp(32'h0, 200);
    imem_req_ready = 1;
    rsp_en = 1;
    if_ready = 1;
    rst_n = 1;
    check("first_addr", imem_req_addr, 32'h0);
    wait_deq(1, "first_deq");
    d0 = ndeq;
    cyc(6);
    check("one_per_cycle", 32'(ndeq - d0), 32'd6);
    // misaligned redirect, then decode stalls: exactly QD requests
    redirect(32'h203, 200);
    f0 = nfire;
    cyc(10);
    check("stall_fires", 32'(nfire - f0), 32'(QD));
    check("stall_req_valid_low", 32'(imem_req_valid), 32'd0);
    if_ready = 1;
    wait_deq(6, "drain_after_stall");
    // redirect with exactly two requests outstanding
    imem_req_ready = 0;
    cyc(4);
    rsp_en = 0;
    cyc(4);
    f0 = nfire;
    imem_req_ready = 1;
    cyc(2);
    imem_req_ready = 0;
    check("two_outstanding", 32'(nfire - f0), 32'd2);
    redirect(32'h100, 200);
    rsp_en = 1;
    imem_req_ready = 1;
    if_ready = 1;
    wait_deq(3, "after_drop");
    // back-to-back redirects: latest wins
    if_ready = 0;
    cyc(1);
    redirect_valid = 1;
    redirect_pc = 32'h500;
    exp_q.delete();
    cyc(1);
    redirect_pc = 32'h600;
    cyc(1);
    redirect_valid = 0;
    push_exp(32'h600, 200);
    check("b2b_addr", imem_req_addr, 32'h600);
    if_ready = 1;
    wait_deq(3, "b2b_deq");
    // 32-bit pc wrap
    redirect(32'hFFFF_FFF8, 200);
    if_ready = 1;
    wait_deq(4, "wrap_deq");
    // predecode samples
    redirect(32'h300, 200);
    if_ready = 1;
    wait_deq(3, "predecode_deq");
    // reset with requests in flight, stale responses after release
    rsp_en = 0;
    cyc(3);
    check("inflight_before_reset", 32'(pend.size() > 0), 32'd1);
    rst_n = 0;
    exp_q.delete();
    #1;
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_if_valid", 32'(if_valid), 32'd0);
    check("mid_rst_if_pc", if_pc, 32'd0);
    imem_req_ready = 0;
    cyc(2);
    rst_n = 1;
    push_exp(32'h0, 200);
    rsp_en = 1;
    cyc(6);
    check("stale_drained", 32'(pend.size()), 32'd0);
    check("stale_ignored", 32'(if_valid), 32'd0);
    check("post_rst_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1;
    if_ready = 1;
    wait_deq(3, "post_rst_deq");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
